// File: rtl/imm_encode_pkg.sv
// Shared constants and types for the immediate encoder.
// Optional range checking is enabled by defining IMM_RANGE_CHECK_EN.
package imm_encode_pkg;

  localparam int TYPE_W    = 3;
  localparam int ERR_CNT_W = 8;
  localparam int INS_W     = 32;

  localparam logic [TYPE_W-1:0] TYPE_I = 3'd0;
  localparam logic [TYPE_W-1:0] TYPE_S = 3'd1;
  localparam logic [TYPE_W-1:0] TYPE_B = 3'd2;
  localparam logic [TYPE_W-1:0] TYPE_U = 3'd3;
  localparam logic [TYPE_W-1:0] TYPE_J = 3'd4;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

  // Payload carried through both pipeline stages.
  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic             err;
  } stage_t;

endpackage

// File: rtl/imm_encode_core.sv
// Combinational immediate insertion into a base instruction word.
// Defining IMM_RANGE_CHECK_EN adds an out-of-range error flag per format.
module imm_encode_core
  import imm_encode_pkg::*;
(
  input  logic [INS_W-1:0]  base,
  input  logic [31:0]       imm,
  input  logic [TYPE_W-1:0] imm_type,
  output logic [INS_W-1:0]  ins,
  output logic              err
);

  logic type_err;
  logic range_err;

  always_comb begin
    ins      = base;
    type_err = 1'b0;
    case (imm_type)
      TYPE_I: ins[31:20] = imm[11:0];
      TYPE_S: begin
        ins[31:25] = imm[11:5];
        ins[11:7]  = imm[4:0];
      end
      TYPE_B: begin
        ins[31]    = imm[12];
        ins[7]     = imm[11];
        ins[30:25] = imm[10:5];
        ins[11:8]  = imm[4:1];
      end
      TYPE_U: ins[31:12] = imm[31:12];
      TYPE_J: begin
        ins[31]    = imm[20];
        ins[30:21] = imm[10:1];
        ins[20]    = imm[11];
        ins[19:12] = imm[19:12];
      end
      default: type_err = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // The upper bits must be a pure sign extension of the encodable field.
  always_comb begin
    range_err = 1'b0;
    case (imm_type)
      TYPE_I, TYPE_S: range_err = !((&imm[31:11]) || !(|imm[31:11]));
      TYPE_B:         range_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      TYPE_U:         range_err = |imm[11:0];
      TYPE_J:         range_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:        range_err = 1'b0;
    endcase
  end
`else
  logic unused_imm_lsb;
  assign unused_imm_lsb = imm[0];
  assign range_err      = 1'b0;
`endif

  assign err = type_err | range_err;

endmodule

// File: rtl/imm_encode.sv
// Two-stage valid/ready pipeline around imm_encode_core with a saturating error counter.
// IMM_RANGE_CHECK_EN (when defined) enables immediate range errors in the core.
module imm_encode
  import imm_encode_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [INS_W-1:0]     BASE,
  input  logic [31:0]          IMM,
  input  logic [TYPE_W-1:0]    TYPE,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [INS_W-1:0]     INS,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  stage_t               s1_q, s1_d;
  stage_t               s2_q, s2_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  stage_t core_out;
  logic   s1_adv;
  logic   in_fire;
  logic   out_fire;

  imm_encode_core u_core (
    .base     (BASE),
    .imm      (IMM),
    .imm_type (TYPE),
    .ins      (core_out.ins),
    .err      (core_out.err)
  );

  // Ready depends only on stored state and OUT_READY, never on IN_VALID.
  always_comb begin
    s1_adv   = s1_valid_q && (!s2_valid_q || OUT_READY);
    IN_READY = !RST && (!s1_valid_q || s1_adv);
    in_fire  = IN_VALID && IN_READY;
    out_fire = s2_valid_q && OUT_READY && !RST;

    s1_valid_d = in_fire || (s1_valid_q && !s1_adv);
    s1_d       = in_fire ? core_out : s1_q;

    s2_valid_d = s1_adv || (s2_valid_q && !OUT_READY);
    s2_d       = s1_adv ? s1_q : s2_q;

    err_cnt_d = err_cnt_q;
    if (out_fire && s2_q.err && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Masking with RST keeps the consumer from seeing a transfer in a reset cycle.
  assign OUT_VALID = s2_valid_q && !RST;
  assign INS       = s2_q.ins;
  assign ERR       = s2_q.err;
  assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_imm_encode.sv
// Directed self-checking bench for imm_encode.
// Expectations for the range-check build follow IMM_RANGE_CHECK_EN.
module tb_imm_encode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] base = '0;
  logic [31:0] imm = '0;
  logic [2:0]  typ = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ins;
  logic        err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int passed = 0;

  imm_encode dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .BASE      (base),
    .IMM       (imm),
    .TYPE      (typ),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .INS       (ins),
    .ERR       (err),
    .ERR_CNT   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] b, input logic [31:0] i, input logic [2:0] t);
    in_valid = 1'b1;
    base     = b;
    imm      = i;
    typ      = t;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready); else passed++;
    checks++; if (ins !== 32'h0 || err !== 1'b0) $display("FAIL reset_ins_err got=%h/%0b exp=0/0", ins, err); else passed++;
    checks++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); else passed++;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_i_type;
    out_ready = 1'b1;
    drive(32'h00000013, 32'hFFFFFFFF, 3'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL i_type_early got=%0b exp=0", out_valid); else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL i_type_valid got=%0b exp=1", out_valid); else passed++;
    checks++; if (ins !== 32'hFFF00013 || err !== 1'b0) $display("FAIL i_type_ins got=%h/%0b exp=fff00013/0", ins, err); else passed++;
    $display("i_type: ins=%h err=%0b", ins, err);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL i_type_drained got=%0b exp=0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] b_tab [3];
    logic [31:0] i_tab [3];
    logic [2:0]  t_tab [3];
    logic [31:0] e_tab [3];
    b_tab[0] = 32'h00000063; i_tab[0] = 32'd8;         t_tab[0] = 3'd2; e_tab[0] = 32'h00000463;
    b_tab[1] = 32'h000000B7; i_tab[1] = 32'h12345000;  t_tab[1] = 3'd3; e_tab[1] = 32'h123450B7;
    b_tab[2] = 32'h0000006F; i_tab[2] = 32'h00000800;  t_tab[2] = 3'd4; e_tab[2] = 32'h0010006F;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2 && c < 5) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got=%0b exp=1", c - 2, out_valid); else passed++;
        checks++; if (ins !== e_tab[c-2] || err !== 1'b0) $display("FAIL b2b_ins[%0d] got=%h/%0b exp=%h/0", c - 2, ins, err, e_tab[c-2]); else passed++;
        $display("b2b: out[%0d] ins=%h err=%0b", c - 2, ins, err);
      end else begin
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_idle[%0d] got=%0b exp=0", c, out_valid); else passed++;
      end
      if (c < 3) drive(b_tab[c], i_tab[c], t_tab[c]);
      else in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_range;
    logic       exp_err;
    logic [7:0] exp_cnt;
`ifdef IMM_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(32'h00000013, 32'h00000800, 3'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || ins !== 32'h80000013 || err !== exp_err)
      $display("FAIL range_i got=%0b/%h/%0b exp=1/80000013/%0b", out_valid, ins, err, exp_err); else passed++;
    @(negedge clk);
    exp_cnt = {7'd0, exp_err};
    checks++; if (err_cnt !== exp_cnt) $display("FAIL range_cnt got=%0d exp=%0d", err_cnt, exp_cnt); else passed++;
    $display("range: i-type 0x800 err=%0b err_cnt=%0d", err, err_cnt);
    drive(32'hDEADBEEF, 32'h00000123, 3'd6);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || ins !== 32'hDEADBEEF || err !== 1'b1)
      $display("FAIL invalid_type got=%0b/%h/%0b exp=1/deadbeef/1", out_valid, ins, err); else passed++;
    @(negedge clk);
    checks++; if (err_cnt !== exp_cnt + 8'd1) $display("FAIL invalid_type_cnt got=%0d exp=%0d", err_cnt, exp_cnt + 8'd1); else passed++;
    $display("range: type 6 ins=%h err_cnt=%0d", ins, err_cnt);
  endtask

  task automatic test_backpressure;
    int          acc = 0;
    logic [31:0] i_tab [3];
    i_tab[0] = 32'd1; i_tab[1] = 32'd2; i_tab[2] = 32'd3;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(32'h00000013, i_tab[acc], 3'd0);
      if (in_ready) acc++;
      @(negedge clk);
    end
    checks++; if (acc != 2) $display("FAIL bp_accepted got=%0d exp=2", acc); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%0b exp=0", in_ready); else passed++;
    checks++; if (out_valid !== 1'b1 || ins !== 32'h00100013) $display("FAIL bp_hold got=%0b/%h exp=1/00100013", out_valid, ins); else passed++;
    $display("bp: accepted=%0d in_ready=%0b", acc, in_ready);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || ins !== 32'h00200013) $display("FAIL bp_second got=%0b/%h exp=1/00200013", out_valid, ins); else passed++;
    $display("bp: second ins=%h", ins);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got=%0b exp=0", out_valid); else passed++;
  endtask

  task automatic test_saturation;
    int n_out = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 304; i++) begin
      if (i < 300) drive(32'h00000000, 32'h0, 3'd5);
      else in_valid = 1'b0;
      if (out_valid && out_ready) n_out++;
      @(negedge clk);
    end
    checks++; if (n_out != 300) $display("FAIL sat_outputs got=%0d exp=300", n_out); else passed++;
    checks++; if (err_cnt !== 8'd255) $display("FAIL sat_err_cnt got=%0d exp=255", err_cnt); else passed++;
    $display("saturation: outputs=%0d err_cnt=%0d", n_out, err_cnt);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(32'h11111111, 32'h0, 3'd6);
    @(negedge clk);
    drive(32'h22222222, 32'h0, 3'd7);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL mid_full got=%0b/%0b exp=1/0", out_valid, in_ready); else passed++;
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL mid_rst_comb got=%0b/%0b exp=0/0", out_valid, in_ready); else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || err_cnt !== 8'd0) $display("FAIL mid_rst_clear got=%0b/%0d exp=0/0", out_valid, err_cnt); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready got=%0b exp=1", in_ready); else passed++;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || err_cnt !== 8'd0) $display("FAIL mid_rst_discard got=%0b/%0d exp=0/0", out_valid, err_cnt); else passed++;
    $display("reset_mid: out_valid=%0b err_cnt=%0d", out_valid, err_cnt);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_i_type;
    test_back_to_back;
    test_range;
    test_backpressure;
    test_saturation;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/imm_encode.md
IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 The block SHALL have the following ports, clock and reset first, in this order: CLK (input, 1 bit; the only clock, all logic acts on the rising edge) and RST (input, 1 bit; synchronous, active-high reset).
REQ-002 IN_VALID  input  1  request carries a valid operand set.
REQ-003 IN_READY  output  1  block accepts a request this cycle.
REQ-004 BASE  input  32  instruction with opcode/rd/rs1/rs2/funct fields; its immediate-bit positions are ignored.
REQ-005 IMM  input  32  immediate value, two's complement.
REQ-006 TYPE  input  3  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J, 5-7 invalid.
REQ-007 OUT_VALID  output  1  INS/ERR are valid.
REQ-008 OUT_READY  input  1  consumer accepts the output.
REQ-009 INS  output  32  encoded instruction.
REQ-010 ERR  output  1  encoding error for this output.
REQ-011 ERR_CNT  output  8  count of accepted outputs with ERR=1.

Function
REQ-012 A transfer SHALL occur on an input when IN_VALID&IN_READY, and on an output when OUT_VALID&OUT_READY, both sampled at the rising CLK edge.
REQ-013 The datapath SHALL be a 2-stage pipeline, stage 1 = encode/check and stage 2 = output register, giving a latency of 2 cycles from input transfer to OUT_VALID with no stalls.
REQ-014 Each stage SHALL load when it is empty or its content moves on in the same cycle; IN_READY = !S1_valid | S1_advances, with no combinational path from IN_VALID to IN_READY.
REQ-015 With OUT_READY held high, the block SHALL sustain one transfer per cycle; under backpressure it SHALL hold 2 entries with no loss, duplication or reordering.
REQ-016 INS SHALL equal BASE with only the immediate bits replaced, as follows.
- I: INS[31:20]=IMM[11:0].
- S: INS[31:25]=IMM[11:5]; INS[11:7]=IMM[4:0].
- B: INS[31]=IMM[12]; INS[7]=IMM[11]; INS[30:25]=IMM[10:5]; INS[11:8]=IMM[4:1].
- U: INS[31:12]=IMM[31:12].
- J: INS[31]=IMM[20]; INS[30:21]=IMM[10:1]; INS[20]=IMM[11]; INS[19:12]=IMM[19:12].
REQ-017 For TYPE 5-7, the block SHALL output INS=BASE and ERR=1.
REQ-018 ERR_CNT SHALL increment on each output transfer with ERR=1 and saturate at 255 without wrapping.
REQ-019 OUT_VALID, INS and ERR SHALL stay stable while OUT_VALID=1 and OUT_READY=0.

Reset
REQ-020 While RST=1 at a clock edge, the block SHALL clear both stage valid flags, INS, ERR and ERR_CNT to 0.
REQ-021 During reset, IN_READY SHALL read 0, and 1 in the first cycle after RST falls.
REQ-022 A reset asserted mid-operation SHALL discard in-flight entries, with no output transfer occurring in that cycle.

Configuration
REQ-023 When IMM_RANGE_CHECK_EN is defined, ERR SHALL additionally be set when IMM is not representable in its format; INS is still encoded from the truncated bits.
- I/S: IMM[31:11] not all equal.
- B: IMM[31:12] not all equal, or IMM[0]=1.
- U: IMM[11:0]!=0.
- J: IMM[31:20] not all equal, or IMM[0]=1.
REQ-024 When IMM_RANGE_CHECK_EN is undefined, ERR SHALL be set only by an invalid TYPE, and no range-check logic SHALL be synthesized.

Structure
REQ-025 A shared package SHALL hold the TYPE code constants (I/S/B/U/J = 0..4), the type width (3), and the ERR_CNT width (8).
REQ-026 The encode/check logic SHALL be one combinational sub-module, imm_encode_core (BASE, IMM, TYPE -> INS, ERR); imm_encode adds the pipeline and handshake around it.

Verification
REQ-027 The bench SHALL cover the following directed scenarios.
- I-type: BASE=0x00000013, IMM=0xFFFFFFFF, OUT_READY=1 -> INS=0xFFF00013, ERR=0, two cycles after the transfer.
- B, U and J types, issued back-to-back with OUT_READY=1:
  - B: BASE=0x00000063, IMM=8 -> 0x00000463.
  - U: BASE=0x000000B7, IMM=0x12345000 -> 0x123450B7.
  - J: BASE=0x0000006F, IMM=0x800 -> 0x0010006F.
  - Outputs arrive on consecutive cycles, ERR=0.
- I-type, BASE=0x00000013, IMM=0x800 -> INS=0x80000013, ERR=1 and ERR_CNT=1 with IMM_RANGE_CHECK_EN; ERR=0 and ERR_CNT=0 without it. TYPE=6 -> INS=BASE, ERR=1 in both builds.
- OUT_READY=0 for 4 cycles with 3 requests offered -> 2 accepted, IN_READY=0 afterwards. On OUT_READY=1, outputs emerge in order with none lost or duplicated.
- 300 invalid-TYPE outputs accepted -> ERR_CNT reaches 255 and holds.
- RST=1 pulsed with 2 entries in flight -> OUT_VALID=0, ERR_CNT=0 next cycle, and IN_READY=1 one cycle after RST falls.
